// File: rtl/alu_operand_loader.sv
// Debounced pushbutton sequencer that loads ALU operands A, B and the opcode from the slide switches.
// Optional macro ALU_LOADER_SWAP_EN enables a KEY[1] operand swap while in S_RUN.
module alu_operand_loader #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  KEY,
  input  logic [17:0] SW,
  output logic [31:0] porta,
  output logic [31:0] portb,
  output logic [3:0]  aluop,
  output logic        op_valid,
  output logic [3:0]  state_led
);

  // State encodings are already one-hot so the LED bus is the state register itself.
  typedef enum logic [3:0] {
    S_A   = 4'b0001,
    S_B   = 4'b0010,
    S_OP  = 4'b0100,
    S_RUN = 4'b1000
  } state_t;

`ifdef ALU_LOADER_SWAP_EN
  localparam logic [3:0] DEB_MASK = 4'b1011;
`else
  localparam logic [3:0] DEB_MASK = 4'b1001;
`endif

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]  key_press;
  logic [16:0] sw_meta;
  logic [16:0] sw_sync;
  logic [31:0] ext;
  logic        unused_inputs;
  state_t      state;

  assign unused_inputs = ^{KEY & ~DEB_MASK, SW[17]};

  for (genvar g = 0; g < 4; g++) begin : g_key
    if (DEB_MASK[g]) begin : g_deb
      logic             meta;
      logic             sync;
      logic             deb;
      logic             press;
      logic [CNT_W-1:0] cnt;

      // Levels rest at 1 (released); a press pulse fires only on the accepted 1->0 flip.
      always_ff @(posedge CLK) begin
        if (RST) begin
          meta  <= 1'b1;
          sync  <= 1'b1;
          deb   <= 1'b1;
          press <= 1'b0;
          cnt   <= '0;
        end else begin
          meta  <= KEY[g];
          sync  <= meta;
          press <= 1'b0;
          if (sync != deb) begin
            if (cnt == CNT_MAX) begin
              deb   <= sync;
              cnt   <= '0;
              press <= ~sync;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else begin
            cnt <= '0;
          end
        end
      end

      assign key_press[g] = press;
    end else begin : g_none
      assign key_press[g] = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= SW[16:0];
      sw_sync <= sw_meta;
    end
  end

  assign ext = {{16{sw_sync[16]}}, sw_sync[15:0]};

  // Clear outranks advance, which outranks swap; at most one transition per cycle.
  always_ff @(posedge CLK) begin
    if (RST || key_press[3]) begin
      porta    <= '0;
      portb    <= '0;
      aluop    <= '0;
      op_valid <= 1'b0;
      state    <= S_A;
    end else begin
      case (state)
        S_A: if (key_press[0]) begin
          porta <= ext;
          state <= S_B;
        end
        S_B: if (key_press[0]) begin
          portb <= ext;
          state <= S_OP;
        end
        S_OP: if (key_press[0]) begin
          aluop    <= sw_sync[3:0];
          op_valid <= 1'b1;
          state    <= S_RUN;
        end
        S_RUN: begin
          if (key_press[0]) begin
            op_valid <= 1'b0;
            state    <= S_A;
          end
`ifdef ALU_LOADER_SWAP_EN
          else if (key_press[1]) begin
            porta <= portb;
            portb <= porta;
          end
`endif
        end
        default: begin
          op_valid <= 1'b0;
          state    <= S_A;
        end
      endcase
    end
  end

  assign state_led = state;

endmodule
